// File: rtl/score_ssd_driver.sv
// score_ssd_driver
//   Time-multiplexes the game status (score tens/ones and lives) onto a
//   4-digit common-anode seven-segment display. Inputs are snapshotted once
//   per frame so every digit in a frame comes from the same sample. The
//   lives digit blinks while exactly one life remains.
//
// Ports
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   score_ones : score units digit (BCD)
//   score_tens : score tens digit (BCD)
//   lives      : remaining lives (BCD)
//   an         : digit anodes, active-low, an[0] = rightmost digit
//   ssd        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low, always off
//
// Build option
//   SSD_LEADING_ZERO_BLANK_EN : blank the tens digit when it is zero.
module score_ssd_driver #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLINK_FRAMES   = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] score_ones,
    input  logic [3:0] score_tens,
    input  logic [3:0] lives,
    output logic [3:0] an,
    output logic [6:0] ssd,
    output logic       dp
);

    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [FW-1:0] fcnt;
    logic          phase;
    logic          valid;
    logic [3:0]    sh_ones, sh_tens, sh_lives;

    logic          frame_end;
    logic          blank;
    logic [3:0]    digit;
    logic [3:0]    an_nxt;
    logic [6:0]    ssd_nxt;

    // Anything outside 0-9 (including unknowns from an upstream block still
    // in reset) falls through to the dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_DASH;
        endcase
    endfunction

    assign frame_end = (cnt == CNT_LAST) && (idx == 2'd3);
    assign dp        = 1'b1;

    // Digit select and blanking for the slot currently addressed by idx.
    always_comb begin
        digit = 4'd0;
        blank = 1'b1;
        case (idx)
            2'd0: begin
                digit = sh_ones;
                blank = 1'b0;
            end
            2'd1: begin
                digit = sh_tens;
`ifdef SSD_LEADING_ZERO_BLANK_EN
                blank = (sh_tens == 4'd0);
`else
                blank = 1'b0;
`endif
            end
            2'd3: begin
                digit = sh_lives;
                // Last life: dark during the phase-0 half of the blink.
                blank = (sh_lives == 4'd1) && !phase;
            end
            default: begin
                digit = 4'd0;
                blank = 1'b1;
            end
        endcase
        if (!valid)
            blank = 1'b1;
        an_nxt  = blank ? 4'b1111 : ~(4'b0001 << idx);
        ssd_nxt = blank ? SEG_BLANK : seg_decode(digit);
    end

    // Reset parks the counters on the last slot of a frame so the first edge
    // after reset is itself a frame end and loads the shadow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= CNT_LAST;
            idx      <= 2'd3;
            fcnt     <= '0;
            phase    <= 1'b1;
            valid    <= 1'b0;
            sh_ones  <= 4'd0;
            sh_tens  <= 4'd0;
            sh_lives <= 4'd0;
            an       <= 4'b1111;
            ssd      <= SEG_BLANK;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (frame_end) begin
                sh_ones  <= score_ones;
                sh_tens  <= score_tens;
                sh_lives <= lives;
                valid    <= 1'b1;
                if (fcnt == FRM_LAST) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end

            // Outputs reflect the pre-edge idx, hence one cycle behind it.
            an  <= an_nxt;
            ssd <= ssd_nxt;
        end
    end

endmodule

// File: tb/tb_score_ssd_driver.sv
// Testbench for score_ssd_driver (REFRESH_CYCLES=4, BLINK_FRAMES=2).
// The stimulus process pushes one expected {an,ssd} per clock edge into a
// queue; an independent monitor pops and compares 2 time units after each
// rising edge.
module tb_score_ssd_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] score_ones, score_tens, lives;
    logic [3:0] an;
    logic [6:0] ssd;
    logic       dp;

    score_ssd_driver #(.REFRESH_CYCLES(4), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .score_ones (score_ones),
        .score_tens (score_tens),
        .lives      (lives),
        .an         (an),
        .ssd        (ssd),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] ssd;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    // Hand-written segment table; index 10 is the dash.
    localparam logic [6:0] SEG [0:10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
        7'b0111111
    };
    localparam logic [3:0] AN [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam int TENS0 = -1;
`else
    localparam int TENS0 = 0;
`endif

    // Push the expectation for the next edge, then step past that edge.
    task automatic cyc(input logic [3:0] a, input logic [6:0] s, input string nm);
        exp_t e;
        e.an   = a;
        e.ssd  = s;
        e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // n edges of digit slot idx showing value v (v < 0 means dark).
    task automatic run(input int idx, input int v, input int n);
        for (int i = 0; i < n; i++) begin
            if (v < 0) cyc(4'b1111, 7'b1111111, $sformatf("slot%0d_blank", idx));
            else       cyc(AN[idx], SEG[v], $sformatf("slot%0d_val%0d", idx, v));
        end
    endtask

    task automatic frame(input int v0, input int v1, input int v3);
        run(0, v0, 4);
        run(1, v1, 4);
        run(2, -1, 4);
        run(3, v3, 4);
    endtask

    // Monitor: compare away from the active edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (an !== e.an || ssd !== e.ssd || dp !== 1'b1) begin
                failed++;
                $display("FAIL %s: got an=%b ssd=%b dp=%b, expected an=%b ssd=%b dp=1",
                         e.name, an, ssd, dp, e.an, e.ssd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; score_ones = 4'd7; score_tens = 4'd3; lives = 4'd3;
        cyc(4'b1111, 7'b1111111, "reset");
        cyc(4'b1111, 7'b1111111, "reset");
        rst = 1'b0;
        cyc(4'b1111, 7'b1111111, "startup_edge1");

        // Frame 1 (phase 1): straight display of the snapshot.
        frame(7, 3, 3);

        // Frame 2 (phase 0): ones changes mid-frame, display holds 7.
        run(0, 7, 4);
        score_ones = 4'd2;
        run(1, 3, 4); run(2, -1, 4); run(3, 3, 4);

        // Frame 3 (phase 0): new ones shows; lives=1 lands on the frame-end edge.
        run(0, 2, 4); run(1, 3, 4); run(2, -1, 4);
        run(3, 3, 3);
        lives = 4'd1;
        run(3, 3, 1);

        // Frames 4-7: last-life blink, visible 2 frames, dark 2 frames.
        frame(2, 3, 1);
        frame(2, 3, 1);
        frame(2, 3, -1);
        frame(2, 3, -1);

        // Frame 8 (phase 1): lives=0 enters the snapshot at frame end.
        run(0, 2, 4);
        lives = 4'd0;
        run(1, 3, 4); run(2, -1, 4); run(3, 1, 4);

        // Frame 9 (phase 1): lives 0 steady; queue non-BCD ones and zero tens.
        run(0, 2, 4);
        score_ones = 4'd12; score_tens = 4'd0;
        run(1, 3, 4); run(2, -1, 4); run(3, 0, 4);

        // Frame 10 (phase 0): dash, zero tens, lives 0 stays lit.
        run(0, 10, 4);
        score_ones = 4'd5;
        run(1, TENS0, 4); run(2, -1, 4); run(3, 0, 4);

        // Frame 11 (phase 0): reset in the middle of the tens slot.
        run(0, 5, 4);
        run(1, TENS0, 2);
        rst = 1'b1; score_ones = 4'd7; score_tens = 4'd3; lives = 4'd1;
        cyc(4'b1111, 7'b1111111, "reset_mid_digit");
        rst = 1'b0;
        cyc(4'b1111, 7'b1111111, "restart_edge1");

        // Start-up repeats with the blink phase restarted visible.
        frame(7, 3, 1);
        frame(7, 3, -1);

        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
